controle_varredura_matriz: RTL and testbench

//  Row-scan controller for the LED matrix. Reads the game matrix memory one row at a

---
 rtl/controle_varredura_matriz.sv | 156 +++++++++++++++
 tb/tb_controle_varredura_matriz.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_varredura_matriz.sv
// LED matrix row-scan controller: reads one row per slot, shows it, blanks, advances.
// Optional VARREDURA_BRILHO_EN adds a brilho[2:0] input that sets the column duty cycle.
module controle_varredura_matriz #(
  parameter int LINHAS        = 8,
  parameter int COLUNAS       = 8,
  parameter int T_LINHA       = 1000,
  parameter int T_APAGA       = 50,
  parameter int QUADROS_PISCA = 25
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      habilita,
  input  logic                      piscar,
`ifdef VARREDURA_BRILHO_EN
  input  logic [2:0]                brilho,
`endif
  input  logic [COLUNAS-1:0]        mem_dados,
  output logic [$clog2(LINHAS)-1:0] mem_endereco,
  output logic                      mem_le,
  output logic [LINHAS-1:0]         linhas,
  output logic [COLUNAS-1:0]        colunas,
  output logic                      quadro_fim,
  output logic [2:0]                db_estado
);

  localparam int AW   = $clog2(LINHAS);
  localparam int TMAX = (T_LINHA > T_APAGA) ? T_LINHA : T_APAGA;
  localparam int CW   = $clog2(TMAX);
  localparam int QW   = $clog2(QUADROS_PISCA + 1);

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] LE_LINHA = 3'd1;
  localparam logic [2:0] ESPERA   = 3'd2;
  localparam logic [2:0] EXIBE    = 3'd3;
  localparam logic [2:0] APAGA    = 3'd4;
  localparam logic [2:0] PROXIMA  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [AW-1:0]      row_q, row_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [QW-1:0]      fcnt_q, fcnt_d;
  logic               vis_q, vis_d;
  logic               visq_q, visq_d;
  logic [COLUNAS-1:0] lin_q, lin_d;
  logic               ultima, fim, acende;

  assign ultima = (row_q == AW'(LINHAS - 1));
  assign fim    = habilita && (state_q == PROXIMA) && ultima;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    lin_d   = lin_q;
    if (!habilita) begin
      state_d = OCIOSO;
      row_d   = '0;
    end else begin
      case (state_q)
        OCIOSO:   state_d = LE_LINHA;
        LE_LINHA: state_d = ESPERA;
        ESPERA: begin
          lin_d   = mem_dados;
          cnt_d   = '0;
          state_d = EXIBE;
        end
        EXIBE: begin
          if (cnt_q == CW'(T_LINHA - 1)) begin
            cnt_d   = '0;
            state_d = APAGA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        APAGA: begin
          if (cnt_q == CW'(T_APAGA - 1)) begin
            cnt_d   = '0;
            state_d = PROXIMA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PROXIMA: begin
          row_d   = ultima ? '0 : row_q + 1'b1;
          state_d = LE_LINHA;
        end
        default: state_d = OCIOSO;
      endcase
    end
  end

  // Blink state changes freely, but the shown visibility only moves at frame starts.
  always_comb begin
    vis_d  = vis_q;
    fcnt_d = fcnt_q;
    visq_d = visq_q;
    if (!piscar) begin
      vis_d  = 1'b1;
      fcnt_d = '0;
    end else if (fim) begin
      if (fcnt_q == QW'(QUADROS_PISCA - 1)) begin
        fcnt_d = '0;
        vis_d  = ~vis_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    if (fim || (habilita && state_q == OCIOSO))
      visq_d = vis_d;
  end

`ifdef VARREDURA_BRILHO_EN
  int lim;
  always_comb begin
    lim    = ((int'(brilho) + 1) * T_LINHA) / 8;
    acende = (int'(cnt_q) < lim);
  end
`else
  assign acende = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= OCIOSO;
      row_q   <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      vis_q   <= 1'b1;
      visq_q  <= 1'b1;
      lin_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      vis_q   <= vis_d;
      visq_q  <= visq_d;
      lin_q   <= lin_d;
    end
  end

  always_comb begin
    mem_endereco = row_q;
    mem_le       = (state_q == LE_LINHA);
    linhas       = '0;
    colunas      = '0;
    if (state_q == EXIBE) begin
      linhas = LINHAS'(1) << row_q;
      if (visq_q && acende)
        colunas = lin_q;
    end
    quadro_fim = fim;
    db_estado  = (state_q > PROXIMA) ? 3'd7 : state_q;
  end

endmodule

// File: tb/tb_controle_varredura_matriz.sv
// Bench for controle_varredura_matriz: timeline reference model plus scenario tasks.
// Build with VARREDURA_BRILHO_EN to also exercise the brightness input.
module tb_controle_varredura_matriz;
  localparam int L  = 4;
  localparam int C  = 4;
`ifdef VARREDURA_BRILHO_EN
  localparam int TL = 8;
`else
  localparam int TL = 4;
`endif
  localparam int TA = 2;
  localparam int QP = 2;
  localparam int P  = 3 + TL + TA;
  localparam int F  = L * P;

  logic         clock = 1'b0;
  logic         reset, habilita, piscar;
  logic [C-1:0] mem_dados;
  logic [1:0]   mem_endereco;
  logic         mem_le;
  logic [L-1:0] linhas;
  logic [C-1:0] colunas;
  logic         quadro_fim;
  logic [2:0]   db_estado;
`ifdef VARREDURA_BRILHO_EN
  logic [2:0]   brilho = 3'd7;
`endif

  logic [C-1:0] mem [L];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  controle_varredura_matriz #(
    .LINHAS(L), .COLUNAS(C), .T_LINHA(TL),
    .T_APAGA(TA), .QUADROS_PISCA(QP)
  ) dut (
    .clock(clock), .reset(reset),
    .habilita(habilita), .piscar(piscar),
`ifdef VARREDURA_BRILHO_EN
    .brilho(brilho),
`endif
    .mem_dados(mem_dados), .mem_endereco(mem_endereco),
    .mem_le(mem_le), .linhas(linhas), .colunas(colunas),
    .quadro_fim(quadro_fim), .db_estado(db_estado)
  );

  // Synchronous-read memory feeding the controller.
  always @(posedge clock)
    if (mem_le) mem_dados <= mem[mem_endereco];

  wire [14:0] obs = {db_estado, mem_le, mem_endereco,
                     linhas, colunas, quadro_fim};

  // Reference: t = cycles since scan start (-1 idle); frame = L row slots of P cycles.
  int t = -1;
  int fc = 0;
  bit vis = 1'b1;
  bit visf = 1'b1;

  function automatic bit nvis();
    if (!piscar) return 1'b1;
    if (habilita && t == F - 1 && fc == QP - 1) return !vis;
    return vis;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      t <= -1; fc <= 0; vis <= 1'b1; visf <= 1'b1;
    end else begin
      vis <= nvis();
      if (!piscar) fc <= 0;
      else if (habilita && t == F - 1)
        fc <= (fc == QP - 1) ? 0 : fc + 1;
      if (!habilita) t <= -1;
      else if (t < 0 || t == F - 1) begin
        t <= 0; visf <= nvis();
      end else t <= t + 1;
    end
  end

  function automatic int lim_m();
`ifdef VARREDURA_BRILHO_EN
    return ((int'(brilho) + 1) * TL) / 8;
`else
    return TL;
`endif
  endfunction

  function automatic logic [14:0] expv();
    int row, o;
    logic [2:0] st;
    logic [3:0] lin, col;
    if (t < 0) return 15'd0;
    row = t / P;
    o = t % P;
    if (o == 0) st = 3'd1;
    else if (o == 1) st = 3'd2;
    else if (o < 2 + TL) st = 3'd3;
    else if (o < 2 + TL + TA) st = 3'd4;
    else st = 3'd5;
    lin = (st == 3'd3) ? 4'(1 << row) : 4'd0;
    col = (st == 3'd3 && visf && (o - 2) < lim_m()) ? mem[row] : 4'd0;
    return {st, (o == 0), 2'(row), lin, col,
            (t == F - 1) && habilita};
  endfunction

  task automatic test_reset();
    reset = 1'b1; habilita = 1'b1; piscar = 1'b0;
    repeat (2) @(negedge clock);
    n_chk++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h expected 0", obs);
    end
    reset = 1'b0; habilita = 1'b0;
    @(negedge clock);
    n_chk++;
    if (db_estado !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idle db_estado got %0d expected 0", db_estado);
    end
  endtask

  task automatic test_scan();
    int qf = 0, lit = 0, last_le = -1;
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    habilita = 1'b1;
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clock);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL scan cyc %0d got %h expected %h", i, obs, expv());
      end
      if (quadro_fim) qf++;
      if (linhas != 0) lit++;
      if (mem_le) begin
        if (last_le >= 0) begin
          n_chk++;
          if (i - last_le !== P) begin
            n_fail++;
            $display("FAIL mem_le_gap got %0d expected %0d", i - last_le, P);
          end
        end
        last_le = i;
      end
    end
    n_chk++;
    if (qf !== 2) begin
      n_fail++;
      $display("FAIL quadro_fim_count got %0d expected 2", qf);
    end
    n_chk++;
    if (lit !== 2 * L * TL) begin
      n_fail++;
      $display("FAIL linhas_cycles got %0d expected %0d", lit, 2 * L * TL);
    end
  endtask

`ifdef VARREDURA_BRILHO_EN
  task automatic test_brilho();
    int on = 0;
    brilho = 3'd3;
    for (int i = 0; i < F; i++) begin
      @(negedge clock);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL brilho cyc %0d got %h expected %h", i, obs, expv());
      end
      if (colunas != 0) on++;
    end
    n_chk++;
    if (on !== L * 4) begin
      n_fail++;
      $display("FAIL brilho_duty got %0d expected %0d", on, L * 4);
    end
    brilho = 3'd7;
  endtask
`endif

  task automatic test_blink();
    int cnt;
    int k;
    bit pat [6] = '{1, 1, 0, 0, 1, 1};
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (t != 0 && k < 2 * F);
    n_chk++;
    if (t != 0) begin
      n_fail++;
      $display("FAIL blink_sync got t=%0d expected 0", t);
    end
    piscar = 1'b1;
    for (int f = 0; f < 8; f++) begin
      cnt = 0;
      for (int i = 0; i < F; i++) begin
        n_chk++;
        if (obs !== expv()) begin
          n_fail++;
          $display("FAIL blink f%0d c%0d got %h expected %h", f, i, obs, expv());
        end
        if (colunas != 0) cnt++;
        if (f == 6 && i == F / 2) piscar = 1'b0;
        @(negedge clock);
      end
      n_chk++;
      if (cnt !== ((f < 6 ? pat[f] : f == 7) ? L * TL : 0)) begin
        n_fail++;
        $display("FAIL blink_frame %0d lit cycles got %0d", f, cnt);
      end
    end
  endtask

  task automatic test_habilita();
    int k = 0;
    while (!(t >= 0 && t / P == 2 && t % P >= 2 && t % P < 2 + TL)
           && k < 2 * F) begin
      @(negedge clock);
      k++;
    end
    n_chk++;
    if (linhas !== 4'b0100) begin
      n_fail++;
      $display("FAIL hab_row2 linhas got %b expected 0100", linhas);
    end
    habilita = 1'b0;
    @(negedge clock);
    n_chk++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL hab_off got %h expected 0", obs);
    end
    @(negedge clock);
    habilita = 1'b1;
    @(negedge clock);
    n_chk++;
    if ({db_estado, mem_le, mem_endereco} !== 6'b001_1_00) begin
      n_fail++;
      $display("FAIL hab_restart got st=%0d le=%b a=%0d expected 1/1/0",
               db_estado, mem_le, mem_endereco);
    end
    for (int i = 0; i < P; i++) begin
      @(negedge clock);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL hab_scan cyc %0d got %h expected %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    while (!(t >= 0 && t % P >= 2 + TL && t % P < 2 + TL + TA)
           && k < 2 * F) begin
      @(negedge clock);
      k++;
    end
    n_chk++;
    if (db_estado !== 3'd4) begin
      n_fail++;
      $display("FAIL arst_apaga db_estado got %0d expected 4", db_estado);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL arst_now got %h expected 0", obs);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < F; i++) begin
      @(negedge clock);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL arst_scan cyc %0d got %h expected %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL rand cyc %0d got %h expected %h", i, obs, expv());
      end
      if ($urandom_range(59) == 0) piscar = ~piscar;
      if ($urandom_range(79) == 0) begin
        habilita = ~habilita;
        if (!habilita)
          for (int r = 0; r < L; r++) mem[r] = 4'($urandom);
      end
`ifdef VARREDURA_BRILHO_EN
      if ($urandom_range(99) == 0) brilho = 3'($urandom);
`endif
    end
  endtask

  initial begin
    reset = 1'b1; habilita = 1'b0; piscar = 1'b0;
    for (int r = 0; r < L; r++) mem[r] = '0;
    test_reset();
    test_scan();
`ifdef VARREDURA_BRILHO_EN
    test_brilho();
`endif
    test_blink();
    test_habilita();
    test_async_reset();
    habilita = 1'b1;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
